// File: rtl/ntt_writeback_address_pipe.sv
// ntt_writeback_address_pipe
//
// Write-side companion to the NTT read address generator for the radix-2,
// 8-butterfly datapath. Every accepted beat (k, i, p) becomes the 16 in-place
// write-back addresses of the 16 butterfly results. The addresses are delayed
// by LATENCY cycles to line up with the butterfly output. The block also
// counts retired beats and pulses stage_done on every 64th write, because a
// stage is 64 beats x 16 coefficients = 1024.
//
// Handshake: there is no backpressure. in_valid marks a beat in the cycle it
// is sampled on a rising edge. The beat is dropped when flush is high in the
// same cycle, or when in_p > 9. wr_valid is a one-cycle strobe and the memory
// must accept it. wr_addr/wr_p are meaningful only while wr_valid is high.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid          beat issued this cycle
//   in_k, in_i        group index / sub-index, 0..63
//   in_p              stage exponent, J = 2^p, legal 0..9
//   flush             synchronous clear of pipeline valids and beat counter
//   wr_valid          write strobe for all 16 lanes
//   wr_addr           16 lanes of AW bits, lane n at [AW*n +: AW]
//   wr_p              p of the beat being written
//   stage_done        pulse coincident with the 64th retired write
//   err               sticky illegal-p flag, cleared only by rst
module ntt_writeback_address_pipe #(
  parameter int LATENCY = 4,
  parameter int AW      = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [5:0]        in_k,
  input  logic [5:0]        in_i,
  input  logic [3:0]        in_p,
  input  logic              flush,
  output logic              wr_valid,
  output logic [16*AW-1:0]  wr_addr,
  output logic [3:0]        wr_p,
  output logic              stage_done,
  output logic              err
);

  // Stage 0 is index 0; the delay line is indices 1..LATENCY.
  logic             pipe_v_q [0:LATENCY];
  logic [3:0]       pipe_p_q [0:LATENCY];
  logic [16*AW-1:0] pipe_a_q [0:LATENCY];

  logic [5:0]       cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [16*AW-1:0] addr_d;
  logic             legal;
  logic             accept;

  assign legal  = (in_p <= 4'd9);
  assign accept = in_valid && legal && !flush;

  // Address generation for the 8 butterfly pairs (2m, 2m+1).
  // p < 3: a group of 16 contiguous coefficients starts at 16k. The even lane
  //        keeps the low p bits of m and moves the rest up one position to
  //        leave room for the J bit; the odd lane adds J.
  // p >= 3: base = 2kJ + 8i. The even lane is base + m; the odd lane sets bit p.
  always_comb begin
    logic [AW-1:0] k_ext;
    logic [AW-1:0] i_ext;
    logic [AW-1:0] j_val;
    logic [AW-1:0] base;
    logic [AW-1:0] m_ext;
    logic [AW-1:0] even_a;
    logic [AW-1:0] odd_a;
    addr_d = '0;
    k_ext  = AW'(in_k);
    i_ext  = AW'(in_i);
    j_val  = AW'(1) << in_p;
    base   = '0;
    m_ext  = '0;
    even_a = '0;
    odd_a  = '0;
    if (in_p >= 4'd3) begin
      base = (k_ext << (in_p + 4'd1)) + (i_ext << 3);
    end else begin
      base = k_ext << 4;
    end
    for (int m = 0; m < 8; m++) begin
      m_ext = AW'(m);
      if (in_p >= 4'd3) begin
        even_a = base + m_ext;
        odd_a  = even_a | j_val;
      end else begin
        even_a = base + ((m_ext >> in_p) << (in_p + 4'd1)) + (m_ext & (j_val - AW'(1)));
        odd_a  = even_a + j_val;
      end
      addr_d[(2*m)*AW   +: AW] = even_a;
      addr_d[(2*m+1)*AW +: AW] = odd_a;
    end
  end

  assign wr_valid   = pipe_v_q[LATENCY];
  assign wr_addr    = pipe_a_q[LATENCY];
  assign wr_p       = pipe_p_q[LATENCY];
  assign stage_done = wr_valid && (cnt_q == 6'd63);
  assign err        = err_q;

  // Counter wraps naturally from 63 to 0 on the stage_done write.
  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (wr_valid) begin
      cnt_d = cnt_q + 6'd1;
    end
  end

  always_comb begin
    err_d = err_q;
    if (in_valid && !legal) begin
      err_d = 1'b1;
    end
  end

  // Payload registers load only when a valid beat moves into them. This keeps
  // wr_addr/wr_p at their last written values while wr_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s <= LATENCY; s++) begin
        pipe_v_q[s] <= 1'b0;
        pipe_p_q[s] <= '0;
        pipe_a_q[s] <= '0;
      end
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      pipe_v_q[0] <= accept;
      if (accept) begin
        pipe_p_q[0] <= in_p;
        pipe_a_q[0] <= addr_d;
      end
      for (int s = 1; s <= LATENCY; s++) begin
        pipe_v_q[s] <= pipe_v_q[s-1] && !flush;
        if (pipe_v_q[s-1] && !flush) begin
          pipe_p_q[s] <= pipe_p_q[s-1];
          pipe_a_q[s] <= pipe_a_q[s-1];
        end
      end
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_ntt_writeback_address_pipe.sv
// Directed bench for ntt_writeback_address_pipe (LATENCY=4, AW=10).
// Inputs are driven on falling edges and outputs are sampled on falling edges.
module tb_ntt_writeback_address_pipe;

  localparam int LAT = 4;
  localparam int AW  = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0;
  logic [5:0]       in_k = '0;
  logic [5:0]       in_i = '0;
  logic [3:0]       in_p = '0;
  logic             flush = 1'b0;
  logic             wr_valid;
  logic [16*AW-1:0] wr_addr;
  logic [3:0]       wr_p;
  logic             stage_done;
  logic             err;

  ntt_writeback_address_pipe #(.LATENCY(LAT), .AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_k(in_k), .in_i(in_i),
    .in_p(in_p), .flush(flush), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_p(wr_p), .stage_done(stage_done), .err(err)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input int k, input int i, input int p);
    in_valid = v;
    in_k     = 6'(k);
    in_i     = 6'(i);
    in_p     = 4'(p);
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [16*AW-1:0] obs,
                       input logic [16*AW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // lane n = start + n
  function automatic logic [16*AW-1:0] mk_seq(input int start);
    logic [16*AW-1:0] e;
    for (int n = 0; n < 16; n++) e[n*AW +: AW] = AW'(start + n);
    return e;
  endfunction

  // even lane 2m = e0 + m, odd lane 2m+1 = o0 + m
  function automatic logic [16*AW-1:0] mk_pair(input int e0, input int o0);
    logic [16*AW-1:0] e;
    for (int m = 0; m < 8; m++) begin
      e[(2*m)*AW   +: AW] = AW'(e0 + m);
      e[(2*m+1)*AW +: AW] = AW'(o0 + m);
    end
    return e;
  endfunction

  // 64-beat run with p=4. With flush_at >= 0, issue beats 0..flush_at, then
  // assert flush together with one more (discarded) beat.
  task automatic run64(input int flush_at, input string tag);
    int j;
    int fc;
    logic ev;
    logic sd;
    fc = flush_at + 1;
    for (int c = 0; c <= 64 + LAT + 2; c++) begin
      j  = c - LAT - 1;
      if (flush_at < 0) ev = (j >= 0) && (j < 64);
      else              ev = (j >= 0) && (j <= flush_at) && (j + LAT + 1 <= fc);
      sd = ev && (j == 63);
      check({tag, "_wr_valid"}, 160'(wr_valid), 160'(ev));
      check({tag, "_stage_done"}, 160'(stage_done), 160'(sd));
      flush = (flush_at >= 0) && (c == fc);
      if (flush_at < 0) drive(c < 64, c, 0, 4);
      else              drive(c <= fc, c, 0, 4);
      tick();
    end
    drive(1'b0, 0, 0, 0);
    flush = 1'b0;
  endtask

  int bk [7];
  int bi [7];
  int bp [7];
  logic [16*AW-1:0] ba [7];

  initial begin
    int j;
    // ---- reset state ----
    tick();
    tick();
    check("rst_wr_valid", 160'(wr_valid), 160'(0));
    check("rst_wr_addr", wr_addr, '0);
    check("rst_wr_p", 160'(wr_p), 160'(0));
    check("rst_stage_done", 160'(stage_done), 160'(0));
    check("rst_err", 160'(err), 160'(0));
    rst = 1'b0;
    tick();

    // ---- single beat p=0 k=1 i=0: latency and hold ----
    drive(1'b1, 1, 0, 0);
    tick();
    drive(1'b0, 0, 0, 0);
    repeat (LAT - 1) tick();
    check("p0_early", 160'(wr_valid), 160'(0));
    tick();
    check("p0_valid", 160'(wr_valid), 160'(1));
    check("p0_addr", wr_addr, mk_seq(16));
    check("p0_wr_p", 160'(wr_p), 160'(0));
    tick();
    check("p0_one_cycle", 160'(wr_valid), 160'(0));
    check("p0_addr_held", wr_addr, mk_seq(16));

    // ---- rst mid-stream loses in-flight beat ----
    drive(1'b1, 2, 0, 0);
    tick();
    drive(1'b0, 0, 0, 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < LAT + 2; c++) begin
      check("rst_mid_no_write", 160'(wr_valid), 160'(0));
      tick();
    end

    // ---- mixed p, back-to-back ----
    bk[0] = 3;  bi[0] = 0;  bp[0] = 2;
    ba[0] = {10'd63, 10'd59, 10'd62, 10'd58, 10'd61, 10'd57, 10'd60, 10'd56,
             10'd55, 10'd51, 10'd54, 10'd50, 10'd53, 10'd49, 10'd52, 10'd48};
    bk[1] = 2;  bi[1] = 1;  bp[1] = 5; ba[1] = mk_pair(136, 168);
    bk[2] = 0;  bi[2] = 63; bp[2] = 9; ba[2] = mk_pair(504, 1016);
    bk[3] = 1;  bi[3] = 63; bp[3] = 9; ba[3] = mk_pair(504, 1016);
    bk[4] = 0;  bi[4] = 0;  bp[4] = 1;
    ba[4] = {10'd15, 10'd13, 10'd14, 10'd12, 10'd11, 10'd9, 10'd10, 10'd8,
             10'd7, 10'd5, 10'd6, 10'd4, 10'd3, 10'd1, 10'd2, 10'd0};
    bk[5] = 5;  bi[5] = 2;  bp[5] = 3; ba[5] = mk_pair(96, 104);
    bk[6] = 63; bi[6] = 7;  bp[6] = 0; ba[6] = mk_seq(1008);
    for (int c = 0; c <= 7 + LAT + 1; c++) begin
      j = c - LAT - 1;
      check("mix_wr_valid", 160'(wr_valid), 160'((j >= 0) && (j < 7)));
      if (j >= 0 && j < 7) begin
        check($sformatf("mix_addr_%0d", j), wr_addr, ba[j]);
        check($sformatf("mix_wr_p_%0d", j), 160'(wr_p), 160'(bp[j]));
      end
      if (c < 7) drive(1'b1, bk[c], bi[c], bp[c]);
      else       drive(1'b0, 0, 0, 0);
      tick();
    end
    check("legal_p_no_err", 160'(err), 160'(0));

    // ---- flush with nothing in flight clears the counter ----
    flush = 1'b1;
    tick();
    flush = 1'b0;

    // ---- 64-beat runs ----
    run64(-1, "run64");
    run64(30, "run_flush");
    run64(-1, "run64_fresh");

    // ---- illegal p ----
    drive(1'b1, 4, 4, 12);
    check("err_before", 160'(err), 160'(0));
    tick();
    drive(1'b0, 0, 0, 0);
    check("err_set", 160'(err), 160'(1));
    for (int c = 0; c < LAT + 2; c++) begin
      check("illegal_no_write", 160'(wr_valid), 160'(0));
      tick();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("err_after_flush", 160'(err), 160'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("err_after_rst", 160'(err), 160'(0));
    check("wr_addr_after_rst", wr_addr, '0);

    // ---- final report ----
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ntt_writeback_address_pipe.md
# ntt_writeback_address_pipe

Write-side companion to the NTT read address generator for the radix-2, 8-butterfly datapath. Each accepted beat (k, i, p) is turned into the 16 in-place write-back addresses for the 16 butterfly results. The addresses are delayed to line up with the butterfly output, then presented with a valid strobe to the coefficient memory. It also counts retired beats and flags completion of each NTT stage (64 beats × 16 coefficients = 1024).

## Interface
Parameters:
- LATENCY, 4: butterfly pipeline depth in cycles (≥1); sets the delay from beat accept to write.
- AW, 10: address width (N = 1024).

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  beat issued this cycle (same cycle the read addresses are issued).
- in_k  in  6  group index, 0..63.
- in_i  in  6  sub-index, 0..63.
- in_p  in  4  stage exponent, J = 2^p, legal 0..9.
- flush  in  1  synchronous clear of pipeline and beat counter.
- wr_valid  out  1  write strobe for all 16 lanes.
- wr_addr  out  16*AW  lane n occupies bits [10n+9:10n].
- wr_p  out  4  p of the beat being written.
- stage_done  out  1  one-cycle pulse on the 64th retired beat.
- err  out  1  sticky; set when an illegal p is issued.

## Operation
- Stage 0 (registered) computes 16 addresses from in_k, in_i, in_p. Lanes pair as (2m, 2m+1), m = 0..7; odd lane = even lane + J.
- p = 0: lane n = 16k + n.
- p = 1: even-lane offsets 0,1,4,5,8,9,12,13; odd lane = even + 2; both added to 16k.
- p = 2: even-lane offsets 0,1,2,3,8,9,10,11; odd lane = even + 4; both added to 16k.
- p = 3..9: base = 2·k·J + 8·i. Even lane 2m = base + m. Odd lane 2m+1 = even lane with bit p forced to 1.
- All arithmetic is modulo 2^AW, with intermediate results truncated to AW bits.
- p > 9 drops the beat (no wr_valid is produced for it) and sets err. err clears only on rst.
- Stages 1..LATENCY form a shift register of {valid, p, 16 addresses}. The register advances every cycle with no stall. wr_* are driven from the last stage.
- Beat counter: 6 bits, increments on each wr_valid. stage_done = wr_valid && counter == 63, after which the counter wraps to 0.
- flush clears every valid bit and the counter on the next edge. An in_valid asserted in the same cycle as flush is discarded. flush does not clear err.

## Timing
- Reset values: wr_valid 0, wr_addr 0, wr_p 0, stage_done 0, err 0, counter 0, all pipeline valid bits 0.
- Latency: a beat accepted at edge t appears with wr_valid at cycle t + LATENCY + 1. Throughput is one beat per cycle, back-to-back.
- wr_addr and wr_p are held at their last values when wr_valid = 0; the memory must ignore them.
- stage_done is coincident with its wr_valid and is never asserted without it.
- Mixed p in flight: each beat carries its own p, so a stage change needs no bubble.
- rst mid-stream: in-flight beats are lost, and no wr_valid appears until a new beat is issued.
- err rises the cycle after the illegal beat is sampled.

## Test plan
- p=0, k=1, i=0, one beat -> after LATENCY+1 cycles, wr_valid=1 for one cycle; lanes 0..15 = 16..31; wr_p=0.
- p=2, k=3 -> lanes 0..7 = 48,52,49,53,50,54,51,55; lanes 8..15 = 56,60,57,61,58,62,59,63.
- p=5, k=2, i=1 -> base 136; even lanes 136..143; odd lanes 168..175.
- p=9, k=0, i=63 -> even lanes 504..511; odd lanes 1016..1023. Repeat with k=1: the 2kJ term wraps to 0 and the lanes are identical.
- 64 back-to-back legal beats -> 64 consecutive wr_valid and a single stage_done on the 64th. Repeat with flush after beat 30 -> all in-flight beats are discarded, and a fresh 64-beat run gives stage_done only on its own 64th write.
- in_p=12 -> no wr_valid for that beat and err=1 the next cycle. err stays set through flush and clears on rst.
